load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 The block SHALL have these core-side ports:
- mem_read  in  1  load request
- mem_write  in  1  store request
- size  in  2  00 word, 01 half, 10 byte; 11 is treated as word
- lb_lh  in  1  1 sign-extends a byte/half load, 0 zero-extends it
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
REQ-003 The block SHALL have these core-side outputs:
- stall  out  1  pipeline hold
- rdata  out  32  extended load result
- rdata_valid  out  1  one-cycle completion pulse
- misalign_exc  out  1  alignment fault
- bus_err  out  1  timeout fault, present only with LSU_TIMEOUT_EN
REQ-004 The block SHALL have these memory-side ports:
- dmem_req  out  1
- dmem_we  out  1
- dmem_be  out  4
- dmem_addr  out  32
- dmem_wdata  out  32
- dmem_ack  in  1
- dmem_rdata  in  32

Function
REQ-005 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-006 A request is an access with mem_read or mem_write high; if both are high, the write SHALL win and the read SHALL be ignored.
REQ-007 Misalignment SHALL be detected as follows:
- half access with addr[0]=1;
- word access with addr[1:0]!=0.
REQ-008 In IDLE with a misaligned request, misalign_exc SHALL be high combinationally, stall SHALL be low, no memory access SHALL start and the state SHALL stay IDLE.
REQ-009 In IDLE with an aligned request, stall SHALL be high combinationally, the memory-side registers SHALL be loaded at the next edge, and the state SHALL go to BUSY.
REQ-010 In BUSY, the outputs SHALL be: dmem_req=1, stall=1, and dmem_addr, dmem_we, dmem_be and dmem_wdata held stable until the edge that samples dmem_ack=1.
REQ-011 dmem_addr SHALL be {addr[31:2],2'b00}.
REQ-012 Byte enables (byte lane 0 = bits 7:0, little-endian) SHALL be:
- byte: 0001 shifted left by addr[1:0];
- half: 0011 when addr[1]=0, 1100 when addr[1]=1;
- word: 1111.
REQ-013 Store data SHALL be:
- byte: wdata[7:0] replicated into all four lanes;
- half: wdata[15:0] replicated into both halves;
- word: wdata unchanged.
REQ-014 A BUSY cycle with dmem_ack=1 SHALL capture the extracted and extended load data into rdata and move to DONE; minimum latency from request to DONE is 2 cycles.
REQ-015 Load extraction SHALL select the byte/half lane from addr[1:0]/addr[1] and then sign- or zero-extend it per lb_lh; a word load SHALL pass dmem_rdata unchanged.
REQ-016 Store completion SHALL leave rdata unchanged.
REQ-017 In DONE, the outputs SHALL be: stall=0, dmem_req=0, rdata_valid=1 for loads only; the state SHALL return to IDLE unconditionally, and the DONE cycle SHALL never start a new access even though the inputs are still held.
REQ-018 dmem_ack SHALL be ignored in IDLE and DONE.

Reset
REQ-019 While rst_n=0 at a clock edge, the state SHALL become IDLE and the registered outputs SHALL reset to: dmem_req=0, dmem_we=0, dmem_be=0000, dmem_addr=0, dmem_wdata=0, rdata=0, rdata_valid=0, bus_err=0.
REQ-020 Reset in BUSY SHALL abandon the access with no completion pulse; an ack arriving after reset SHALL be ignored.

Configuration
REQ-021 With macro LSU_TIMEOUT_EN defined, the timeout feature SHALL operate as follows:
- an 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack;
- when it reaches 255, the next edge SHALL go to DONE with bus_err=1 for one cycle, rdata_valid=0 and rdata unchanged;
- an ack on the 255th cycle SHALL take priority over the timeout.
REQ-022 Without LSU_TIMEOUT_EN, the bus_err port and the counter SHALL be absent and BUSY SHALL wait indefinitely.

Verification
REQ-023 lb with addr=0x00000103, dmem_rdata=0x80FFFFFF, ack on the first BUSY cycle -> dmem_be=0001 was not issued (be=1000); rdata=0xFFFFFF80, rdata_valid pulses once, stall high for exactly 2 cycles.
REQ-024 sh with addr=0x00000042, wdata=0x1234ABCD -> dmem_addr=0x00000040, dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1; rdata_valid stays 0.
REQ-025 lw with addr=0x00000006 -> misalign_exc=1 in the same cycle, dmem_req never asserts, stall=0.
REQ-026 lhu with addr=0x10, ack delayed 5 cycles, dmem_rdata=0x0000F00D -> request signals stable for 6 BUSY cycles; rdata=0x0000F00D.
REQ-027 rst_n driven low during BUSY with an ack one cycle later -> IDLE, dmem_req=0, no rdata_valid pulse.
REQ-028 With LSU_TIMEOUT_EN, sw with no ack -> bus_err pulses after 255 BUSY cycles, stall releases in DONE, and the FSM returns to IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access to a req/ack data memory, with lane steering and load extension.
// Define LSU_TIMEOUT_EN to add the bus_err port and a 255-cycle BUSY timeout.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        lb_lh,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign_exc,
`ifdef LSU_TIMEOUT_EN
  output logic        bus_err,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t      state_reg, state_next;

  logic        is_req;
  logic        is_write;
  logic        misaligned;
  logic        start;
  logic        complete;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Attributes of the access in flight, needed to extend the returning load data.
  logic [1:0]  ld_size_reg;
  logic        ld_sign_reg;
  logic [1:0]  ld_off_reg;
  logic        is_load_reg;

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]  tmo_cnt_reg;
  logic        timeout;
`endif

  assign is_req   = mem_read | mem_write;
  assign is_write = mem_write;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (size)
      SZ_BYTE: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[ld_off_reg];
  assign half_sel = ld_off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_ext = dmem_rdata;
    case (ld_size_reg)
      SZ_BYTE: load_ext = ld_sign_reg ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      SZ_HALF: load_ext = ld_sign_reg ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Next state and the combinational core-side handshake outputs.
  always_comb begin
    state_next   = state_reg;
    stall        = 1'b0;
    misalign_exc = 1'b0;
    start        = 1'b0;
    complete     = 1'b0;
`ifdef LSU_TIMEOUT_EN
    timeout      = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (is_req) begin
          if (misaligned) begin
            misalign_exc = 1'b1;
          end else begin
            stall      = 1'b1;
            start      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_ack) begin
          complete   = 1'b1;
          state_next = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_cnt_reg == 8'd254) begin
          // This is the 255th BUSY cycle without ack; an ack here still wins.
          timeout    = 1'b1;
          state_next = DONE;
        end
`endif
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_be     <= 4'b0000;
      dmem_addr   <= 32'h0;
      dmem_wdata  <= 32'h0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      ld_size_reg <= 2'b00;
      ld_sign_reg <= 1'b0;
      ld_off_reg  <= 2'b00;
      is_load_reg <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err     <= 1'b0;
      tmo_cnt_reg <= 8'd0;
`endif
    end else begin
      state_reg   <= state_next;
      rdata_valid <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err     <= 1'b0;
`endif
      if (start) begin
        dmem_req    <= 1'b1;
        dmem_we     <= is_write;
        dmem_be     <= be_calc;
        dmem_addr   <= {addr[31:2], 2'b00};
        dmem_wdata  <= wdata_calc;
        ld_size_reg <= size;
        ld_sign_reg <= lb_lh;
        ld_off_reg  <= addr[1:0];
        is_load_reg <= ~is_write;
`ifdef LSU_TIMEOUT_EN
        tmo_cnt_reg <= 8'd0;
`endif
      end
      if (complete) begin
        dmem_req <= 1'b0;
        if (is_load_reg) begin
          rdata       <= load_ext;
          rdata_valid <= 1'b1;
        end
      end
`ifdef LSU_TIMEOUT_EN
      if (timeout) begin
        dmem_req <= 1'b0;
        bus_err  <= 1'b1;
      end
      if (state_reg == BUSY && !dmem_ack && !timeout) begin
        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level driver sets per-cycle expectations
// from a behavioural model, and one negedge process compares every output.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        lb_lh;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign_exc;
`ifdef LSU_TIMEOUT_EN
  logic        bus_err;
  logic        exp_bus_err;
`endif
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .size         (size),
    .lb_lh        (lb_lh),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .misalign_exc (misalign_exc),
`ifdef LSU_TIMEOUT_EN
    .bus_err      (bus_err),
`endif
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_be      (dmem_be),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expectations for the current cycle, written by the driver just after posedge.
  bit          chk_en = 0;
  logic        exp_stall, exp_misalign, exp_req, exp_rvalid, exp_we;
  bit          exp_fields;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata;
  logic [31:0] rdata_model;

  bit          lit_en = 0;
  logic        lit_we;
  logic [3:0]  lit_be;
  logic [31:0] lit_addr, lit_wdata, lit_rdata;
  bit          lit_rd_en = 0;

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b10) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b10) return 4'b0001 << a[1:0];
    if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b10) return {4{wd[7:0]}};
    if (sz == 2'b01) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    int unsigned off;
    off = a[1:0];
    if (sz == 2'b10) begin
      sh = rd >> (8 * off);
      return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    end
    if (sz == 2'b01) begin
      sh = a[1] ? (rd >> 16) : rd;
      return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    end
    return rd;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'h0, stall}, {31'h0, exp_stall});
      chk("misalign_exc", {31'h0, misalign_exc}, {31'h0, exp_misalign});
      chk("dmem_req", {31'h0, dmem_req}, {31'h0, exp_req});
      chk("rdata_valid", {31'h0, rdata_valid}, {31'h0, exp_rvalid});
      chk("rdata", rdata, rdata_model);
`ifdef LSU_TIMEOUT_EN
      chk("bus_err", {31'h0, bus_err}, {31'h0, exp_bus_err});
`endif
      if (exp_fields) begin
        chk("dmem_we", {31'h0, dmem_we}, {31'h0, exp_we});
        chk("dmem_be", {28'h0, dmem_be}, {28'h0, exp_be});
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_wdata", dmem_wdata, exp_wdata);
        if (lit_en) begin
          chk("lit_we", {31'h0, dmem_we}, {31'h0, lit_we});
          chk("lit_be", {28'h0, dmem_be}, {28'h0, lit_be});
          chk("lit_addr", dmem_addr, lit_addr);
          chk("lit_wdata", dmem_wdata, lit_wdata);
        end
      end
      if (lit_rd_en && exp_rvalid) chk("lit_rdata", rdata, lit_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_misalign = 1'b0; exp_req = 1'b0; exp_rvalid = 1'b0;
    exp_fields = 1'b0;
`ifdef LSU_TIMEOUT_EN
    exp_bus_err = 1'b0;
`endif
  endtask

  // One core access; delay = number of BUSY cycles before the ack cycle.
  task automatic txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                     input logic [31:0] a, input logic [31:0] wd, input int delay,
                     input logic [31:0] rdv);
    bit is_load, tmo;
    int i;
    is_load = rd & ~wr;
    tmo = 1'b0;
    mem_read = rd; mem_write = wr; size = sz; lb_lh = sgn; addr = a; wdata = wd;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    set_idle_exp();
    if (!(rd | wr)) begin
      step();
      return;
    end
    if (m_misaligned(sz, a)) begin
      exp_misalign = 1'b1;
      step();
    end else begin
      exp_stall = 1'b1;
      step();
      i = 0;
      while (i < 1000) begin
        dmem_ack   = (i == delay);
        dmem_rdata = (i == delay) ? rdv : $urandom;
        exp_stall  = 1'b1; exp_req = 1'b1; exp_fields = 1'b1;
        exp_we     = wr;
        exp_be     = m_be(sz, a);
        exp_addr   = {a[31:2], 2'b00};
        exp_wdata  = m_wdata(sz, wd);
        step();
        if (i == delay) break;
`ifdef LSU_TIMEOUT_EN
        if (i == 254) begin
          tmo = 1'b1;
          break;
        end
`endif
        i++;
      end
      if (is_load && !tmo) rdata_model = m_load(sz, sgn, a, rdv);
      set_idle_exp();
      exp_rvalid = is_load && !tmo;
`ifdef LSU_TIMEOUT_EN
      exp_bus_err = tmo;
`endif
      dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      step();
    end
    mem_read = 1'b0; mem_write = 1'b0;
    dmem_ack = 1'($urandom_range(0, 1));
    set_idle_exp();
    step();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; lb_lh = 1'b0;
    addr = 32'h0; wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    rdata_model = 32'h0;
    set_idle_exp();
    step();
    step();
    rst_n = 1'b1;
    exp_fields = 1'b1; exp_we = 1'b0; exp_be = 4'b0000; exp_addr = 32'h0; exp_wdata = 32'h0;
    chk_en = 1;
    step();

    // lb from the top byte lane, sign-extended
    lit_en = 1; lit_rd_en = 1;
    lit_we = 1'b0; lit_be = 4'b1000; lit_addr = 32'h0000_0100; lit_wdata = 32'h0;
    lit_rdata = 32'hFFFF_FF80;
    txn(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80FF_FFFF);
    // sh to the upper half
    lit_rd_en = 0;
    lit_we = 1'b1; lit_be = 4'b1100; lit_addr = 32'h0000_0040; lit_wdata = 32'hABCD_ABCD;
    txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h1234_ABCD, 2, 32'h0);
    lit_en = 0;
    // misaligned lw
    txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 0, 32'h0);
    // lhu with a 5-cycle ack delay
    lit_en = 1; lit_rd_en = 1;
    lit_we = 1'b0; lit_be = 4'b0011; lit_addr = 32'h0000_0010; lit_wdata = 32'h0;
    lit_rdata = 32'h0000_F00D;
    txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0, 5, 32'h0000_F00D);
    lit_en = 0; lit_rd_en = 0;
    // read and write together: the write wins
    txn(1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 1, 32'h1111_2222);

    for (int n = 0; n < 250; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (sz == 2'b10) ? a[1:0] : (sz == 2'b01 ? {a[1], 1'b0} : 2'b00);
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
          a, $urandom, int'($urandom_range(0, 6)), $urandom);
    end

`ifdef LSU_TIMEOUT_EN
    txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 400, 32'h0);
    txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0304, 32'h0, 254, 32'h5A5A_A5A5);
`endif

    // make rdata non-zero, then reset in BUSY with an ack arriving just after
    txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0400, 32'h0, 0, 32'h7654_3210);
    mem_read = 1'b1; mem_write = 1'b0; size = 2'b00; addr = 32'h0000_0020; dmem_ack = 1'b0;
    set_idle_exp();
    exp_stall = 1'b1;
    step();
    rst_n = 1'b0;
    exp_req = 1'b1; exp_fields = 1'b1; exp_we = 1'b0; exp_be = 4'b1111;
    exp_addr = 32'h0000_0020; exp_wdata = m_wdata(2'b00, wdata);
    step();
    rst_n = 1'b1; mem_read = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    rdata_model = 32'h0;
    set_idle_exp();
    exp_fields = 1'b1; exp_we = 1'b0; exp_be = 4'b0000; exp_addr = 32'h0; exp_wdata = 32'h0;
    step();
    dmem_ack = 1'b0;
    step();
    set_idle_exp();
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0501, 32'h0, 3, 32'h0000_AB00);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
